ec_fpn_mult_ctl: RTL

Scalar-multiplication sequencer for Jacobian-coordinate EC points over Fp or Fp2. It accepts a point P and scalar k and runs right-to-left double-and-add, computing k·P. Doublings go to an external `ec_fpn_dbl` and additions to an external `ec_fpn_add`; both are driven through AXI-stream request/response pairs and overlapped in the same iteration. It sits between the prover's MSM front end and the shared point-arithmetic units.

---
 rtl/ec_fpn_mult_ctl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ec_fpn_mult_ctl.sv
// ---------------------------------------------------------------------------
// ec_fpn_mult_ctl
//
// Scalar-multiplication sequencer for Jacobian EC points (Fp or Fp2).
// It takes a point P and a scalar k and computes k*P with right-to-left
// double-and-add. Point doubling and point addition are done by external
// units (ec_fpn_dbl / ec_fpn_add). Both units are reached through
// valid/ready request/response pairs. A doubling and an addition from the
// same iteration run at the same time.
//
// The AXI-stream interfaces are flattened into <if>_<field> ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pt_if_*             command in:  dat = {k, P}, ctl sideband
//   o_pt_if_*             result out:  dat = k*P (all-zero = infinity),
//                         ctl = command ctl, single beat (sop = eop = 1)
//   o_dbl_if_* / i_dbl_if_*   doubling request (Q) / response (2Q)
//   o_add_if_* / i_add_if_*   addition request ({Q, R}) / response (R+Q)
//
// The response ready outputs are always 1. A response is used only when its
// pend flag is set. A response from an aborted command can still arrive after
// a reset; because the pend flag is clear at that point, the response is
// dropped.
// ---------------------------------------------------------------------------
module ec_fpn_mult_ctl #(
    parameter int PT_BITS  = 2286,   // $bits of the Fp2 Jacobian point struct
    parameter int K_BITS   = 256,
    parameter int CTL_BITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,

    input  logic                      i_pt_if_val,
    input  logic [PT_BITS+K_BITS-1:0] i_pt_if_dat,
    input  logic [CTL_BITS-1:0]       i_pt_if_ctl,
    output logic                      i_pt_if_rdy,

    output logic                      o_pt_if_val,
    output logic [PT_BITS-1:0]        o_pt_if_dat,
    output logic [CTL_BITS-1:0]       o_pt_if_ctl,
    output logic                      o_pt_if_sop,
    output logic                      o_pt_if_eop,
    input  logic                      o_pt_if_rdy,

    output logic                      o_dbl_if_val,
    output logic [PT_BITS-1:0]        o_dbl_if_dat,
    output logic [CTL_BITS-1:0]       o_dbl_if_ctl,
    input  logic                      o_dbl_if_rdy,

    input  logic                      i_dbl_if_val,
    input  logic [PT_BITS-1:0]        i_dbl_if_dat,
    output logic                      i_dbl_if_rdy,

    output logic                      o_add_if_val,
    output logic [2*PT_BITS-1:0]      o_add_if_dat,
    output logic [CTL_BITS-1:0]       o_add_if_ctl,
    input  logic                      o_add_if_rdy,

    input  logic                      i_add_if_val,
    input  logic [PT_BITS-1:0]        i_add_if_dat,
    output logic                      i_add_if_rdy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]          state;
    logic [PT_BITS-1:0]  q;          // running 2^i * P
    logic [PT_BITS-1:0]  r;          // accumulator, meaningless while r_inf
    logic                r_inf;
    logic [K_BITS-1:0]   k_sh;
    logic [CTL_BITS-1:0] ctl_r;
    logic                pend_dbl;
    logic                pend_add;
    logic                issued;     // this iteration's requests are raised

    logic [K_BITS-1:0]   k_in;
    logic [K_BITS-1:0]   k_nxt;
    logic                need_dbl;
    logic                need_add;
    logic                dbl_busy;
    logic                add_busy;

    assign k_in     = i_pt_if_dat[PT_BITS +: K_BITS];
    assign k_nxt    = k_sh >> 1;
    // A doubling is needed only if a higher bit is still set. This keeps the
    // doubling count at the index of the MSB of k.
    assign need_dbl = |k_nxt;
    // The first set bit loads R directly. Only later set bits cost an add.
    assign need_add = k_sh[0] & ~r_inf;
    // The request is still outstanding after the coming edge.
    assign dbl_busy = o_dbl_if_val & ~o_dbl_if_rdy;
    assign add_busy = o_add_if_val & ~o_add_if_rdy;

    // rdy is also gated by reset, so the command port stays closed while
    // reset is held.
    assign i_pt_if_rdy  = (state == IDLE) & ~i_rst;
    assign i_dbl_if_rdy = 1'b1;
    assign i_add_if_rdy = 1'b1;

    assign o_pt_if_val  = (state == DONE);
    assign o_pt_if_dat  = r_inf ? '0 : r;
    assign o_pt_if_ctl  = ctl_r;
    assign o_pt_if_sop  = 1'b1;
    assign o_pt_if_eop  = 1'b1;

    assign o_dbl_if_ctl = ctl_r;
    assign o_add_if_ctl = ctl_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            r_inf        <= 1'b1;
            pend_dbl     <= 1'b0;
            pend_add     <= 1'b0;
            issued       <= 1'b0;
            o_dbl_if_val <= 1'b0;
            o_add_if_val <= 1'b0;
        end else begin
            // Each request drops on its own handshake. The request dat is a
            // snapshot taken at issue time, so it stays stable even if Q or R
            // change under it.
            if (o_dbl_if_rdy) o_dbl_if_val <= 1'b0;
            if (o_add_if_rdy) o_add_if_val <= 1'b0;

            // Responses can arrive in any state and in any order. A response
            // with no matching pend flag is ignored.
            if (i_dbl_if_val && pend_dbl) begin
                q        <= i_dbl_if_dat;
                pend_dbl <= 1'b0;
            end
            if (i_add_if_val && pend_add) begin
                r        <= i_add_if_dat;
                pend_add <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_pt_if_val) begin
                        q     <= i_pt_if_dat[PT_BITS-1:0];
                        k_sh  <= k_in;
                        r_inf <= 1'b1;
                        ctl_r <= i_pt_if_ctl;
                        state <= (k_in == '0) ? DONE : ISSUE;
                    end
                end

                ISSUE: begin
                    if (!issued) begin
                        if (k_sh[0] && r_inf) begin
                            r     <= q;
                            r_inf <= 1'b0;
                        end
                        if (need_add) begin
                            o_add_if_val <= 1'b1;
                            o_add_if_dat <= {q, r};
                            pend_add     <= 1'b1;
                        end
                        if (need_dbl) begin
                            o_dbl_if_val <= 1'b1;
                            o_dbl_if_dat <= q;
                            pend_dbl     <= 1'b1;
                        end
                        if (need_add || need_dbl) begin
                            issued <= 1'b1;
                        end else begin
                            // Nothing goes out, so this iteration ends in
                            // this cycle.
                            k_sh  <= k_nxt;
                            state <= (k_nxt == '0) ? DONE : ISSUE;
                        end
                    end else if (!dbl_busy && !add_busy) begin
                        issued <= 1'b0;
                        state  <= WAIT;
                    end
                end

                WAIT: begin
                    if (!pend_dbl && !pend_add) begin
                        k_sh  <= k_nxt;
                        state <= need_dbl ? ISSUE : DONE;
                    end
                end

                DONE: begin
                    if (o_pt_if_rdy) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
